instr_encoder: RTL and testbench

- Inverse of the single-cycle core's instruction decoder.
- Accepts a mnemonic selector plus register and immediate fields over a valid/ready handshake.
- Range-checks the fields, assembles a 32-bit RV32I instruction word, and writes it into instruction memory at an auto-incrementing address.
- Used to load waveform programs into the function generator core without an external toolchain.

---
 rtl/instr_encoder.sv | 156 +++++++++++++++
 tb/tb_instr_encoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Mnemonic-driven RV32I instruction assembler that streams encoded words into
// instruction memory at an auto-incrementing word address.
module instr_encoder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  input  logic              ptr_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              err_pulse,
  output logic              err_flag,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  typedef enum logic [1:0] {IDLE, ENCODE, WRITE, FULL} state_t;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_t;

  state_t           state, next_state;
  fmt_t             fmt;
  logic [4:0]       op_q, rd_q, rs1_q, rs2_q;
  logic [31:0]      imm_q;
  logic [2:0]       f3;
  logic [6:0]       f7, opc;
  logic [31:0]      word;
  logic             legal;
  logic [CNT_W-1:0] count_inc;
  logic             i_ok, b_ok, j_ok;

  assign count_inc = count + 1'b1;
  assign full      = (count == CNT_W'(DEPTH));

  // Range checks: the upper bits must be a pure sign extension of the field.
  assign i_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign b_ok = ((&imm_q[31:12]) | ~(|imm_q[31:12])) & ~imm_q[0];
  assign j_ok = ((&imm_q[31:20]) | ~(|imm_q[31:20])) & ~imm_q[0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid && in_ready) next_state = ENCODE;
      ENCODE:  next_state = legal ? WRITE : IDLE;
      WRITE:   next_state = (count_inc == CNT_W'(DEPTH)) ? FULL : IDLE;
      FULL:    next_state = FULL;
      default: next_state = IDLE;
    endcase
    if (ptr_clr) next_state = IDLE;
  end

  always_comb begin
    in_ready  = (state == IDLE) && !full;
    mem_we    = (state == WRITE) && !rst;
    err_pulse = (state == ENCODE) && !legal && !rst;
  end

  always_comb begin
    fmt = FMT_BAD;
    f3  = 3'b000;
    f7  = 7'b0000000;
    opc = 7'b0000000;
    case (op_q)
      5'd0:  begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b000; end
      5'd1:  begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b000; f7 = 7'b0100000; end
      5'd2:  begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b111; end
      5'd3:  begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b110; end
      5'd4:  begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b010; end
      5'd5:  begin fmt = FMT_R; opc = 7'b0110011; f3 = 3'b011; end
      5'd6:  begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b000; end
      5'd7:  begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b100; end
      5'd8:  begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b110; end
      5'd9:  begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b010; end
      5'd10: begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b011; end
      5'd11: begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b010; end
      5'd12: begin fmt = FMT_S; opc = 7'b0100011; f3 = 3'b010; end
      5'd13: begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b000; end
      5'd14: begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b001; end
      5'd15: begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b100; end
      5'd16: begin fmt = FMT_B; opc = 7'b1100011; f3 = 3'b101; end
      5'd17: begin fmt = FMT_U; opc = 7'b0110111; end
      5'd18: begin fmt = FMT_J; opc = 7'b1101111; end
      5'd19: begin fmt = FMT_I; opc = 7'b1100111; f3 = 3'b000; end
      default: fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      FMT_R: begin word = {f7, rs2_q, rs1_q, f3, rd_q, opc}; legal = 1'b1; end
      FMT_I: begin word = {imm_q[11:0], rs1_q, f3, rd_q, opc}; legal = i_ok; end
      FMT_S: begin word = {imm_q[11:5], rs2_q, rs1_q, f3, imm_q[4:0], opc}; legal = i_ok; end
      FMT_B: begin
        word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3, imm_q[4:1], imm_q[11], opc};
        legal = b_ok;
      end
      FMT_U: begin word = {imm_q[31:12], rd_q, opc}; legal = (imm_q[11:0] == 12'd0); end
      FMT_J: begin
        word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opc};
        legal = j_ok;
      end
      default: begin word = '0; legal = 1'b0; end
    endcase
  end

  // ptr_clr is applied last so it overrides the WRITE-state pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_flag  <= 1'b0;
      count     <= '0;
    end else begin
      if (state == IDLE && in_valid && in_ready) begin
        op_q  <= op_sel;
        rd_q  <= rd;
        rs1_q <= rs1;
        rs2_q <= rs2;
        imm_q <= imm;
      end
      if (state == ENCODE && legal)  mem_wdata <= word;
      if (state == ENCODE && !legal) err_flag  <= 1'b1;
      if (state == WRITE) begin
        count    <= count_inc;
        mem_addr <= mem_addr + ADDR_W'(4);
      end
      if (ptr_clr) begin
        count    <= '0;
        mem_addr <= '0;
        err_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases followed by random
// requests compared against an arithmetic RV32I encoding model.
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              ptr_clr = 1'b0;
  logic [4:0]        op_sel = '0, rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0]       imm = '0;
  logic              in_ready, mem_we, err_pulse, err_flag, full;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [CNT_W-1:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_count = 0;
  bit exp_err = 1'b0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .ptr_clr(ptr_clr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .err_pulse(err_pulse), .err_flag(err_flag),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: field placement written as shifts and masks of the ISA layout.
  function automatic void ref_encode(input int op, input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [31:0] im,
                                     output bit ok, output logic [31:0] w);
    int f3_of[20] = '{0, 0, 7, 6, 2, 3, 0, 4, 6, 2, 3, 2, 2, 0, 1, 4, 5, 0, 0, 0};
    int v;
    logic [31:0] f3, opc, rd_f, rs1_f, rs2_f;
    v = im;
    ok = 1'b0;
    w = '0;
    f3 = (op >= 0 && op < 20) ? 32'(f3_of[op]) : 32'd0;
    rd_f = 32'(d) << 7;
    rs1_f = 32'(s1) << 15;
    rs2_f = 32'(s2) << 20;
    if (op >= 0 && op <= 5) begin
      ok = 1'b1;
      w = ((op == 1) ? (32'd32 << 25) : 32'd0) | rs2_f | rs1_f | (f3 << 12) | rd_f | 32'h33;
    end else if ((op >= 6 && op <= 11) || op == 19) begin
      opc = (op == 11) ? 32'h03 : (op == 19) ? 32'h67 : 32'h13;
      ok = (v >= -2048) && (v <= 2047);
      w = ((im & 32'hFFF) << 20) | rs1_f | (f3 << 12) | rd_f | opc;
    end else if (op == 12) begin
      ok = (v >= -2048) && (v <= 2047);
      w = (((im >> 5) & 32'h7F) << 25) | rs2_f | rs1_f | (32'd2 << 12) | ((im & 32'h1F) << 7) | 32'h23;
    end else if (op >= 13 && op <= 16) begin
      ok = ((im & 32'd1) == 0) && (v >= -4096) && (v <= 4094);
      w = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'h3F) << 25) | rs2_f | rs1_f |
          (f3 << 12) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'd1) << 7) | 32'h63;
    end else if (op == 17) begin
      ok = ((im & 32'hFFF) == 0);
      w = (im & 32'hFFFFF000) | rd_f | 32'h37;
    end else if (op == 18) begin
      ok = ((im & 32'd1) == 0) && (v >= -1048576) && (v <= 1048574);
      w = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
          (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'hFF) << 12) | rd_f | 32'h6F;
    end
  endfunction

  task automatic check_reset(input string tag);
    check_output({tag, "_in_ready"}, in_ready, 1);
    check_output({tag, "_mem_we"}, mem_we, 0);
    check_output({tag, "_mem_addr"}, mem_addr, 0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 0);
    check_output({tag, "_err_pulse"}, err_pulse, 0);
    check_output({tag, "_err_flag"}, err_flag, 0);
    check_output({tag, "_count"}, count, 0);
    check_output({tag, "_full"}, full, 0);
  endtask

  // Entered at the negedge right after the accepting clock edge.
  task automatic observe(input int op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im, input string tag);
    bit ok;
    logic [31:0] w;
    ref_encode(op, d, s1, s2, im, ok, w);
    check_output({tag, "_err_pulse"}, err_pulse, {31'd0, !ok});
    check_output({tag, "_we_early"}, mem_we, 0);
    @(negedge clk);
    if (ok) begin
      check_output({tag, "_we"}, mem_we, 1);
      check_output({tag, "_addr"}, mem_addr, 32'(4 * exp_count));
      check_output({tag, "_wdata"}, mem_wdata, w);
      exp_count++;
    end else begin
      check_output({tag, "_no_we"}, mem_we, 0);
      check_output({tag, "_pulse_end"}, err_pulse, 0);
      exp_err = 1'b1;
    end
    check_output({tag, "_err_flag"}, err_flag, {31'd0, exp_err});
    @(negedge clk);
    check_output({tag, "_count"}, count, 32'(exp_count));
    check_output({tag, "_full"}, full, {31'd0, exp_count == DEPTH});
    check_output({tag, "_we_after"}, mem_we, 0);
  endtask

  task automatic apply_stimulus(input int op, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [31:0] im, input string tag);
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge clk);
    check_output({tag, "_ready"}, in_ready, 1);
    op_sel = 5'(op);
    rd = d;
    rs1 = s1;
    rs2 = s2;
    imm = im;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    observe(op, d, s1, s2, im, tag);
  endtask

  task automatic do_ptr_clr(input string tag);
    ptr_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ptr_clr = 1'b0;
    exp_count = 0;
    exp_err = 1'b0;
    check_output({tag, "_count"}, count, 0);
    check_output({tag, "_addr"}, mem_addr, 0);
    check_output({tag, "_err_flag"}, err_flag, 0);
    check_output({tag, "_full"}, full, 0);
  endtask

  initial begin
    int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4096, -4097,
                    1048574, -1048576, 1048576, 3, -1, 0};
    int op;
    logic [31:0] im;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset("por");

    apply_stimulus(0, 5'd3, 5'd1, 5'd2, 32'd0, "add");
    do_ptr_clr("clr1");
    apply_stimulus(6, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, "addi_m1");
    apply_stimulus(12, 5'd0, 5'd1, 5'd2, 32'd8, "sw");
    do_ptr_clr("clr2");
    apply_stimulus(13, 5'd0, 5'd1, 5'd2, 32'd8, "beq");
    apply_stimulus(18, 5'd1, 5'd0, 5'd0, 32'd16, "jal");
    apply_stimulus(17, 5'd7, 5'd0, 5'd0, 32'h1234_5000, "lui");
    apply_stimulus(6, 5'd1, 5'd1, 5'd0, 32'd2048, "addi_big");
    apply_stimulus(13, 5'd0, 5'd1, 5'd2, 32'd3, "beq_odd");
    apply_stimulus(25, 5'd1, 5'd1, 5'd1, 32'd0, "bad_op");
    apply_stimulus(6, 5'd1, 5'd1, 5'd0, 32'd5, "fill");
    check_output("full_ready", in_ready, 0);

    op_sel = 5'd3;
    rd = 5'd9;
    rs1 = 5'd4;
    rs2 = 5'd6;
    imm = 32'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("stall_ready", in_ready, 0);
      check_output("stall_we", mem_we, 0);
      check_output("stall_count", count, 32'(DEPTH));
    end
    ptr_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ptr_clr = 1'b0;
    exp_count = 0;
    exp_err = 1'b0;
    check_output("unstall_count", count, 0);
    check_output("unstall_ready", in_ready, 1);
    check_output("unstall_err", err_flag, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    observe(3, 5'd9, 5'd4, 5'd6, 32'd0, "held_or");

    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) @(negedge clk);
    op_sel = 5'd0;
    rd = 5'd2;
    rs1 = 5'd3;
    rs2 = 5'd4;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("rst_we", mem_we, 0);
    rst = 1'b0;
    exp_count = 0;
    exp_err = 1'b0;
    check_reset("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("rst_no_we", mem_we, 0);
    end

    for (int n = 0; n < 60; n++) begin
      if (exp_count == DEPTH) do_ptr_clr("rclr");
      op = int'($urandom_range(0, 23));
      case ($urandom_range(0, 5))
        0: im = 32'(int'($urandom_range(0, 4095)) - 2048);
        1: im = 32'(bnd[$urandom_range(0, 13)]);
        2: im = $urandom;
        3: im = $urandom & 32'hFFFF_F000;
        4: im = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
        default: im = 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
      endcase
      apply_stimulus(op, 5'($urandom), 5'($urandom), 5'($urandom), im, "rand");
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
